apb_master_bridge: RTL and testbench

- Converts a simple valid/ready command interface into APB transfers, and returns one response per command.
- Sits directly upstream of the team's APB slave: drives pselx/penable/pwrite/paddr/pwdata and consumes pready/prdata.
- Adds a bounded wait-state timeout so a stuck slave cannot hang the requester.

---
 rtl/apb_master_bridge.sv | 133 +++++++++++++
 tb/tb_apb_master_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into APB transfers.
// Each accepted command runs one SETUP cycle and one or more ACCESS cycles,
// then emits a one-cycle response pulse. A bounded wait-state counter aborts
// the transfer with rsp_err=1 if the slave never raises pready.
module apb_master_bridge #(
   parameter int addr_width     = 5,
   parameter int data_width     = 16,
   parameter int timeout_cycles = 16   // legal range 2..255
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   // requester side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [addr_width-1:0] cmd_addr,
   input  logic [data_width-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [data_width-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   // APB side
   output logic                  pselx,
   output logic                  penable,
   output logic                  pwrite,
   output logic [addr_width-1:0] paddr,
   output logic [data_width-1:0] pwdata,
   input  logic                  pready,
   input  logic [data_width-1:0] prdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Compare value for the last permitted ACCESS cycle; the counter starts
   // at 0 on entry to ACCESS, so this yields exactly timeout_cycles cycles.
   localparam logic [7:0] last_wait = 8'(timeout_cycles - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       timed_out;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign timed_out = (wait_cnt == last_wait);

   // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE sequence.
   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt; a
      // missing branch would otherwise infer a latch.
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready || timed_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset drops the bridge straight back to IDLE.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state <= IDLE;
      end else begin
         // NOTE: non-blocking assignment for every sequential register so all
         // flops update together from pre-edge values.
         state <= state_nxt;
      end
   end

   // Registered APB drive, wait counter and response outputs.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         pselx     <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         // Response flags are single-cycle pulses unless re-set below.
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               penable <= 1'b0;
               if (accept) begin
                  pwrite <= cmd_write;
                  paddr  <= cmd_addr;
                  pwdata <= cmd_wdata;
                  pselx  <= 1'b1;
               end else begin
                  pselx  <= 1'b0;
               end
            end
            SETUP: begin
               penable  <= 1'b1;
               wait_cnt <= '0;
            end
            ACCESS: begin
               if (pready) begin
                  pselx     <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  if (!pwrite) rsp_rdata <= prdata;
               end else if (timed_out) begin
                  pselx     <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  wait_cnt  <= wait_cnt + 8'd1;
               end
            end
            default: begin
               pselx   <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge.
// A driver issues commands and pushes the model's expected response; a
// behavioural APB slave answers with a chosen number of wait states; a
// monitor pops and compares on every rsp_valid and watches bus stability.
module tb_apb_master_bridge;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int TO = 4;
   localparam int NEVER = 255;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          err;
      logic [DW-1:0] rdata;
      int            cycles;
   } exp_t;

   logic          pclk = 1'b0;
   logic          preset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic          pselx;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t exp_q[$];
   int   waits_q[$];

   // reference model state
   logic [DW-1:0] ref_mem [2**AW];
   logic [DW-1:0] ref_last_rdata;
   // behavioural slave storage
   logic [DW-1:0] slave_mem [2**AW];

   apb_master_bridge #(
      .addr_width    (AW),
      .data_width    (DW),
      .timeout_cycles(TO)
   ) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .pselx    (pselx),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pready   (pready),
      .prdata   (prdata)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outcome of one command from its wait-state count.
   task automatic model_push(input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int waits);
      exp_t e;
      e.wr    = wr;
      e.addr  = a;
      e.wdata = d;
      e.err   = (waits >= TO);
      if (e.err) begin
         e.cycles       = TO;
         e.rdata        = '0;
         ref_last_rdata = '0;
      end else begin
         e.cycles = waits + 1;
         if (wr) begin
            ref_mem[a] = d;
            e.rdata    = ref_last_rdata;
         end else begin
            e.rdata        = ref_mem[a];
            ref_last_rdata = ref_mem[a];
         end
      end
      exp_q.push_back(e);
      waits_q.push_back(waits);
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int waits);
      int n = 0;
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 100) begin
         @(negedge pclk);
         n++;
      end
      check("accept_bound", 32'(n < 100), 32'd1);
      if (n < 100) model_push(wr, a, d, waits);
   endtask

   task automatic idle(input int k);
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (k) @(negedge pclk);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge pclk);
         n++;
      end
      check("drain_bound", 32'(n < 2000), 32'd1);
   endtask

   // Behavioural APB slave: ready after the chosen number of wait states.
   initial begin
      int cur_waits = 0;
      int acc_k     = 0;
      pready = 1'b0;
      prdata = '0;
      forever begin
         @(negedge pclk);
         if (!preset_n) begin
            pready = 1'b0;
            acc_k  = 0;
         end else if (pselx && !penable) begin
            if (waits_q.size() != 0) cur_waits = waits_q.pop_front();
            else cur_waits = NEVER;
            acc_k  = 0;
            pready = 1'b0;
         end else if (pselx && penable) begin
            pready = (acc_k == cur_waits);
            prdata = pready ? slave_mem[paddr] : DW'($urandom);
            if (pready && pwrite) slave_mem[paddr] = pwdata;
            acc_k++;
         end else begin
            pready = 1'b0;
            prdata = DW'($urandom);
         end
      end
   end

   // Monitor: protocol stability and response scoreboard.
   initial begin
      logic          prev_sel = 1'b0;
      logic          prev_pen = 1'b0;
      logic          prev_rsp = 1'b0;
      logic [AW-1:0] cap_addr = '0;
      logic [DW-1:0] cap_wdata = '0;
      logic          cap_wr = 1'b0;
      int            access_cnt = 0;
      exp_t          e;
      forever begin
         @(negedge pclk);
         if (!preset_n) begin
            prev_sel   = 1'b0;
            prev_pen   = 1'b0;
            prev_rsp   = 1'b0;
            access_cnt = 0;
         end else begin
            if (pselx && !penable) begin
               check("setup_after_idle", 32'({prev_sel, prev_pen}), 32'd0);
               if (exp_q.size() == 0) begin
                  check("setup_unexpected", 32'd1, 32'd0);
               end else begin
                  check("setup_paddr",  32'(paddr),  32'(exp_q[0].addr));
                  check("setup_pwrite", 32'(pwrite), 32'(exp_q[0].wr));
                  check("setup_pwdata", 32'(pwdata), 32'(exp_q[0].wdata));
               end
               cap_addr   = paddr;
               cap_wdata  = pwdata;
               cap_wr     = pwrite;
               access_cnt = 0;
            end else if (pselx && penable) begin
               check("access_paddr_stable",  32'(paddr),  32'(cap_addr));
               check("access_pwdata_stable", 32'(pwdata), 32'(cap_wdata));
               check("access_pwrite_stable", 32'(pwrite), 32'(cap_wr));
               access_cnt++;
            end else if (penable) begin
               check("penable_without_psel", 32'(penable), 32'd0);
            end

            if (rsp_valid) begin
               check("rsp_pulse_single", 32'(prev_rsp), 32'd0);
               check("rsp_bus_released", 32'({pselx, penable}), 32'd0);
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_err",    32'(rsp_err),   32'(e.err));
                  check("rsp_rdata",  32'(rsp_rdata), 32'(e.rdata));
                  check("access_len", 32'(access_cnt), 32'(e.cycles));
               end
            end else begin
               check("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
            prev_sel = pselx;
            prev_pen = penable;
            prev_rsp = rsp_valid;
         end
      end
   end

   // Global guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // Main stimulus sequence.
   initial begin
      int n;
      logic [DW-1:0] v;
      for (int i = 0; i < 2**AW; i++) begin
         v            = DW'($urandom);
         ref_mem[i]   = v;
         slave_mem[i] = v;
      end
      ref_mem[3]     = 16'h1234;
      slave_mem[3]   = 16'h1234;
      ref_last_rdata = '0;

      // Reset with a pending command: outputs idle, cmd_ready high.
      preset_n  = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 5'h11;
      cmd_wdata = 16'h5A5A;
      repeat (3) @(negedge pclk);
      check("rst_pselx",     32'(pselx),     32'd0);
      check("rst_penable",   32'(penable),   32'd0);
      check("rst_pwrite",    32'(pwrite),    32'd0);
      check("rst_paddr",     32'(paddr),     32'd0);
      check("rst_pwdata",    32'(pwdata),    32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      model_push(1'b1, 5'h11, 16'h5A5A, 1);
      preset_n = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      check("post_rst_pselx",     32'(pselx),     32'd1);
      check("post_rst_penable",   32'(penable),   32'd0);
      check("post_rst_busy",      32'(busy),      32'd1);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      drain();
      idle(1);

      // Write, zero wait states.
      issue(1'b1, 5'h0A, 16'hBEEF, 0);
      idle(0);
      drain();
      // Read, three wait states.
      issue(1'b0, 5'h03, 16'h0000, 3);
      idle(0);
      drain();
      // Timeout: slave never ready.
      issue(1'b0, 5'h07, 16'h0000, NEVER);
      idle(0);
      drain();
      // Back-to-back with cmd_valid held high.
      issue(1'b1, 5'h03, 16'hCAFE, 1);
      issue(1'b0, 5'h03, 16'h0000, 0);
      idle(0);
      drain();

      // Randomized traffic, including random timeouts.
      for (int i = 0; i < 60; i++) begin
         issue(1'(($urandom) & 1), AW'($urandom), DW'($urandom), int'($urandom_range(0, 6)));
         if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 2)));
      end
      idle(0);
      drain();

      // Reset during a read wait state: bus drops at once, no response.
      issue(1'b0, 5'h05, 16'h0000, NEVER);
      idle(0);
      n = 0;
      while (!penable && n < 50) begin
         @(negedge pclk);
         n++;
      end
      check("mid_reach_access", 32'(penable), 32'd1);
      @(negedge pclk);
      #2 preset_n = 1'b0;
      #1;
      check("mid_rst_pselx",   32'(pselx),   32'd0);
      check("mid_rst_penable", 32'(penable), 32'd0);
      check("mid_rst_busy",    32'(busy),    32'd0);
      exp_q.delete();
      waits_q.delete();
      ref_last_rdata = '0;
      @(negedge pclk);
      preset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Recovery transaction after the mid-transfer reset.
      issue(1'b0, 5'h03, 16'h0000, 1);
      idle(0);
      drain();
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
